// File: rtl/fbs_stack.sv
// fbs_stack: multi-level snapshot stack for the f-register file (push = backup, pop = restore).
// Define FBS_OVF_PROTECT_EN to drop pushes on a full stack and flag over/underflow on err; otherwise circular.
module fbs_stack #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             backup,
    input  logic             restore,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut,
    output logic             dataValid,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty,
    output logic             err
);

    localparam logic [AW-1:0] WP_ONE   = 1;
    localparam logic [AW:0]   LVL_ONE  = 1;
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW:0]      level_q, level_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dvalid_q, dvalid_d;
    logic             err_q, err_d;
    logic [AW-1:0]    top_ptr;
    logic [AW-1:0]    wr_addr;
    logic             wr_en;
    logic             err_set;
    logic             is_empty, is_full;

    assign is_empty = (level_q == '0);
    assign is_full  = (level_q == LVL_FULL);
    assign top_ptr  = wp_q - WP_ONE;

    always_comb begin
        wp_d     = wp_q;
        level_d  = level_q;
        dout_d   = dout_q;
        dvalid_d = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = wp_q;
        err_set  = 1'b0;
        if (backup && restore && !is_empty) begin
            // Replace-top: read the old top out while overwriting it in the same edge.
            dout_d   = mem_q[top_ptr];
            wr_en    = 1'b1;
            wr_addr  = top_ptr;
            dvalid_d = 1'b1;
        end else if (backup) begin
            if (!is_full) begin
                wr_en   = 1'b1;
                wp_d    = wp_q + WP_ONE;
                level_d = level_q + LVL_ONE;
            end else begin
`ifdef FBS_OVF_PROTECT_EN
                err_set = 1'b1;
`else
                // Circular: the slot at wp is the oldest one once the stack is full.
                wr_en = 1'b1;
                wp_d  = wp_q + WP_ONE;
`endif
            end
        end else if (restore) begin
            if (!is_empty) begin
                dout_d   = mem_q[top_ptr];
                wp_d     = top_ptr;
                level_d  = level_q - LVL_ONE;
                dvalid_d = 1'b1;
            end else begin
`ifdef FBS_OVF_PROTECT_EN
                err_set = 1'b1;
`endif
            end
        end
        // err_set never fires in the circular build, so err stays at its reset value of 0.
        err_d = err_set | (err_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q     <= '0;
            level_q  <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wp_q     <= wp_d;
            level_q  <= level_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            err_q    <= err_d;
        end
    end

    // Snapshot storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= dataIn;
        end
    end

    assign dataOut   = dout_q;
    assign dataValid = dvalid_q;
    assign level     = level_q;
    assign full      = is_full;
    assign empty     = is_empty;
    assign err       = err_q;

endmodule

// File: tb/tb_fbs_stack.sv
// Testbench for fbs_stack (WIDTH=256, DEPTH=4): directed scenarios plus random traffic against a queue model.
module tb_fbs_stack;
  localparam int W = 256;
  localparam int D = 4;

  logic         clk;
  logic         rst_n;
  logic         backup;
  logic         restore;
  logic         clr_err;
  logic [W-1:0] dataIn;
  logic [W-1:0] dataOut;
  logic         dataValid;
  logic [2:0]   level;
  logic         full;
  logic         empty;
  logic         err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] stk[$];
  logic         m_err;
  logic         exp_valid;

  fbs_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .backup(backup), .restore(restore), .clr_err(clr_err),
    .dataIn(dataIn), .dataOut(dataOut), .dataValid(dataValid), .level(level),
    .full(full), .empty(empty), .err(err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // monitor: every dataValid pulse must match the oldest outstanding expected pop
  always @(negedge clk) begin
    if (rst_n && dataValid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_data: unexpected dataValid with dataOut %h", dataOut);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (dataOut !== e) begin
          n_fail++;
          $display("FAIL pop_data: got %h expected %h", dataOut, e);
        end
      end
    end
  end

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W / 32; i++) w = {w[W-33:0], 32'($urandom())};
    return w;
  endfunction

  // reference model: a plain queue, back = top of stack
  task automatic model_step(input logic b, input logic r, input logic c, input logic [W-1:0] d);
    logic err_set;
    err_set   = 1'b0;
    exp_valid = 1'b0;
    if (b && r && stk.size() > 0) begin
      exp_q.push_back(stk[stk.size()-1]);
      stk[stk.size()-1] = d;
      exp_valid = 1'b1;
    end else if (b) begin
      if (stk.size() < D) begin
        stk.push_back(d);
      end else begin
`ifdef FBS_OVF_PROTECT_EN
        err_set = 1'b1;
`else
        void'(stk.pop_front());
        stk.push_back(d);
`endif
      end
    end else if (r) begin
      if (stk.size() > 0) begin
        exp_q.push_back(stk.pop_back());
        exp_valid = 1'b1;
      end else begin
`ifdef FBS_OVF_PROTECT_EN
        err_set = 1'b1;
`endif
      end
    end
    if (err_set) m_err = 1'b1;
    else if (c) m_err = 1'b0;
  endtask

  // driver: called right after a negedge; applies one operation for one clock
  task automatic op(input logic b, input logic r, input logic c, input logic [W-1:0] d);
    backup  = b;
    restore = r;
    clr_err = c;
    dataIn  = d;
    model_step(b, r, c, d);
    @(posedge clk);
    @(negedge clk);
    backup  = 1'b0;
    restore = 1'b0;
    clr_err = 1'b0;
    check("dataValid", W'(dataValid), W'(exp_valid));
    check("level", W'(level), W'(stk.size()));
    check("full", W'(full), W'(stk.size() == D));
    check("empty", W'(empty), W'(stk.size() == 0));
    check("err", W'(err), W'(m_err));
  endtask

  initial begin
    rst_n   = 1'b0;
    backup  = 1'b0;
    restore = 1'b0;
    clr_err = 1'b0;
    dataIn  = '0;
    m_err   = 1'b0;
    exp_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_level", W'(level), '0);
    check("rst_empty", W'(empty), W'(1));
    check("rst_full", W'(full), '0);
    check("rst_dataOut", dataOut, '0);
    check("rst_dataValid", W'(dataValid), '0);
    check("rst_err", W'(err), '0);
    rst_n = 1'b1;
    op(0, 0, 0, '0);

    // LIFO order
    op(1, 0, 0, W'(32'hA));
    op(1, 0, 0, W'(32'hB));
    op(1, 0, 0, W'(32'hC));
    repeat (3) op(0, 1, 0, '0);

    // fill, push on full, drain
    for (int i = 1; i <= 5; i++) op(1, 0, 0, W'(i));
    repeat (4) op(0, 1, 0, '0);

    // replace-top
    op(1, 0, 0, W'(32'h11));
    op(1, 1, 0, W'(32'h22));
    op(0, 1, 0, '0);

    // underflow and err clearing; set beats clear
    op(0, 1, 0, '0);
    op(0, 0, 1, '0);
    op(0, 1, 1, '0);
    op(0, 0, 1, '0);
    // replace-top on empty behaves as a push
    op(1, 1, 0, W'(32'h33));
    op(0, 1, 0, '0);

    // asynchronous reset between edges
    op(1, 0, 0, W'(32'h44));
    op(1, 0, 0, W'(32'h55));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_level", W'(level), '0);
    check("async_dataOut", dataOut, '0);
    check("async_empty", W'(empty), W'(1));
    check("async_dataValid", W'(dataValid), '0);
    stk.delete();
    m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    op(1, 0, 0, W'(32'h66));
    op(0, 1, 0, '0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), rand_word());
    end
    op(0, 0, 0, '0);

    check("exp_q_drained", W'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule

// File: doc/fbs_stack.md
# fbs_stack

Parametrised multi-level snapshot stack for the f-register file, the next generation of the single-slot f-register backup system. It sits beside the f-register file: `backup` pushes a full register-file image, and `restore` pops the most recent image back out. Compared with the previous backup system, it adds:

- configurable width and depth;
- full/empty/level status;
- defined behaviour when backup and restore are asserted together;
- a registered, validated read port;
- compile-time choice between overflow protection and circular overwrite.

## Interface
Parameters:
- WIDTH, 256, bits per snapshot (whole f-register file image)
- DEPTH, 16, number of snapshot slots; power of two, ≥2; AW = $clog2(DEPTH)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- backup  input  1  push dataIn as a new snapshot this cycle
- restore  input  1  pop the most recent snapshot this cycle
- clr_err  input  1  clears err (present in both configurations; ignored when err is tied 0)
- dataIn  input  WIDTH  snapshot to store
- dataOut  output  WIDTH  last popped snapshot; registered; holds until the next pop
- dataValid  output  1  one-cycle pulse, high the cycle after a successful pop
- level  output  AW+1  number of valid snapshots, 0..DEPTH
- full  output  1  level == DEPTH
- empty  output  1  level == 0
- err  output  1  sticky overflow/underflow flag

## Operation
- State:
  - write pointer wp (AW bits, modulo DEPTH);
  - level counter (AW+1 bits);
  - storage array mem[DEPTH][WIDTH];
  - output register dataOut;
  - dataValid flop;
  - err flop.
- Top of stack is mem[wp-1] (mod DEPTH).
- Reset (rst_n low, async):
  - wp=0, level=0, dataOut=0, dataValid=0, err=0;
  - full=0, empty=1;
  - mem contents are not reset.
- Idle (backup=0, restore=0): no state change; dataValid=0.
- backup only, not full: mem[wp]←dataIn, wp←wp+1, level←level+1.
- backup only, full: handling depends on FBS_OVF_PROTECT_EN (see Configuration).
- restore only, not empty: dataOut←mem[wp-1], wp←wp-1, level←level-1, dataValid←1.
- restore only, empty: no pointer/level/dataOut change; dataValid←0; err←1 if FBS_OVF_PROTECT_EN is defined.
- backup and restore together (replace-top):
  - Not empty: dataOut←mem[wp-1] (old contents, read-before-write), mem[wp-1]←dataIn, dataValid←1, wp and level unchanged. Legal even when full; never an error.
  - Empty: behaves as backup only; dataValid←0.
- err:
  - Set has priority over clr_err in the same cycle.
  - Otherwise cleared by clr_err.
- level, full and empty are derived from the registered level and settle in the same cycle as the update.

## Timing
- Write latency: the snapshot is committed at the rising edge that samples backup=1. A restore in the very next cycle returns it.
- Read latency: 1 cycle. dataOut and dataValid update at the edge sampling restore=1.
- dataValid is high for exactly one cycle per successful pop. Back-to-back restores give consecutive pulses with successive snapshots.
- All status outputs are registered or decoded from registers; there are no combinational paths from inputs to outputs.
- Reset asserted mid-operation clears state immediately, without waiting for clk. The first operation accepted is at the first rising edge after rst_n rises.

## Configuration
- FBS_OVF_PROTECT_EN defined:
  - backup only on a full stack is dropped: mem, wp and level unchanged; err←1.
  - restore on an empty stack sets err.
- FBS_OVF_PROTECT_EN undefined:
  - The stack is circular. backup only on a full stack overwrites the oldest slot (mem[wp]←dataIn, wp←wp+1) with level held at DEPTH.
  - restore on empty is silently ignored.
  - err is tied 0.

## Test plan
Directed tests use WIDTH=256, DEPTH=4.
- Reset then idle: level=0, empty=1, full=0, dataOut=0, dataValid=0, err=0.
- Push 0xA, 0xB, 0xC, then pop three times: dataOut sequence 0xC, 0xB, 0xA, each with a one-cycle dataValid; level ends at 0, empty=1.
- Push 1,2,3,4 (full=1), push 5, then pop four times:
  - With the macro defined: err=1; pops return 4,3,2,1.
  - Without it: err=0; pops return 5,4,3,2 (oldest value 1 is overwritten), then empty=1.
- Push 0x11, then assert backup and restore together with dataIn=0x22: dataOut=0x11, dataValid=1, level stays 1. A following pop returns 0x22.
- Pop on empty: dataValid=0, level=0. err=1 with the macro defined (0 without). Assert clr_err: err returns to 0. Assert clr_err in the same cycle as a new underflow: err stays 1.
- Push 2 snapshots, then drop rst_n asynchronously between edges: level=0, dataOut=0 immediately. After release, the first push/pop pair returns the newly pushed value.
